// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream synchronous FIFO and transmits them
// as asynchronous serial frames (start bit, 8 data bits LSB first, optional even
// parity, 1 or 2 stop bits). Back-to-back bytes are separated only by the two
// cycles spent fetching and loading the next byte.
//
// Parameters:
//   CLKS_PER_BIT - rd_clk cycles per serial bit, 2..65535
//   STOP_BITS    - number of stop bits, 1 or 2
//
// Ports:
//   rd_clk       - single clock (FIFO read clock)
//   rd_rst_n     - asynchronous active-low reset
//   i_fifo_empty - upstream FIFO empty flag
//   i_rd_data    - upstream FIFO read data, valid the cycle after rd_en
//   rd_en        - FIFO pop request, one cycle per byte
//   o_tx         - serial line, idle high, driven from a flop
//   o_busy       - high whenever a byte is being fetched or transmitted
//   o_tx_done    - one-cycle pulse in the last cycle of the final stop bit
//   o_byte_cnt   - wrapping count of completed frames
//
// Build option:
//   UART_PARITY_EN - when defined, an even parity bit is sent between the data
//                    bits and the stop bit(s).

module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic        rd_clk,
  input  logic        rd_rst_n,
  input  logic        i_fifo_empty,
  input  logic [7:0]  i_rd_data,
  output logic        rd_en,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_tx_done,
  output logic [15:0] o_byte_cnt
);

  localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  StopLast = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStart,
    StData,
`ifdef UART_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        armed_q;
  logic        baud_end;
  logic        done;
`ifdef UART_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign baud_end = (baud_q == BaudLast);

  // Next-state, counters and datapath
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + 16'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    done       = 1'b0;
`ifdef UART_PARITY_EN
    parity_d   = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        // armed_q holds off the first fetch until the second edge after reset
        if (armed_q && !i_fifo_empty) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        state_d = StLoad;
      end
      StLoad: begin
        shift_d   = i_rd_data;
        bit_cnt_d = '0;
`ifdef UART_PARITY_EN
        parity_d  = ^i_rd_data;
`endif
        state_d   = StStart;
      end
      StStart: begin
        if (baud_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (baud_end) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            baud_d    = '0;
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (baud_end) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (baud_end) begin
          if (bit_cnt_q == StopLast) begin
            done       = 1'b1;
            byte_cnt_d = byte_cnt_q + 16'd1;
            state_d    = i_fifo_empty ? StIdle : StFetch;
          end else begin
            // bit_cnt counts stop bits so the baud counter stays 16 bits wide
            bit_cnt_d = bit_cnt_q + 3'd1;
            baud_d    = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Every state change restarts bit timing
    if (state_d != state_q) begin
      baud_d    = '0;
      bit_cnt_d = '0;
    end
  end

  // Line level is decoded from the next state so the flop lines up with state_q
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      StParity: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      byte_cnt_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      byte_cnt_q <= byte_cnt_d;
      armed_q    <= 1'b1;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign rd_en      = (state_q == StFetch);
  assign o_busy     = (state_q != StIdle);
  assign o_tx       = tx_q;
  assign o_tx_done  = done;
  assign o_byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4,
// STOP_BITS=1. A small FIFO model feeds bytes; frames are checked sample by
// sample on the falling clock edge against hand-written bit patterns.

`timescale 1ns/1ps

module tb_fifo_uart_tx;

  localparam int Clks = 4;
`ifdef UART_PARITY_EN
  localparam int NBits = 11;
`else
  localparam int NBits = 10;
`endif

  logic        rd_clk = 1'b0;
  logic        rd_rst_n = 1'b0;
  logic        i_fifo_empty;
  logic [7:0]  i_rd_data;
  logic        rd_en;
  logic        o_tx;
  logic        o_busy;
  logic        o_tx_done;
  logic [15:0] o_byte_cnt;

  always #5 rd_clk = ~rd_clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(Clks),
    .STOP_BITS   (1)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst_n    (rd_rst_n),
    .i_fifo_empty(i_fifo_empty),
    .i_rd_data   (i_rd_data),
    .rd_en       (rd_en),
    .o_tx        (o_tx),
    .o_busy      (o_busy),
    .o_tx_done   (o_tx_done),
    .o_byte_cnt  (o_byte_cnt)
  );

  // FIFO model: data appears the cycle after rd_en
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign i_fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge rd_clk) begin
    if (rd_en) begin
      i_rd_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  int rd_en_cnt = 0;
  always @(negedge rd_clk) begin
    if (rd_en) rd_en_cnt <= rd_en_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // frame: start, data LSB first, stop, written first-bit-leftmost
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [10:0] expand(input vec_t v);
    logic [10:0] r;
`ifdef UART_PARITY_EN
    r = {v.frame[9:1], v.par, 1'b1};
`else
    r = {1'b0, v.frame};
`endif
    return r;
  endfunction

  task automatic wait_start(input string name);
    int n = 0;
    while (o_tx !== 1'b0 && n < 50) begin
      @(negedge rd_clk);
      n++;
    end
    chk({name, " start bit seen"}, 32'(n < 50), 32'd1);
  endtask

  // Called at the first sample of the start bit; returns one sample past the frame
  task automatic check_frame(input string name, input logic [10:0] exp, input logic [15:0] cnt);
    for (int k = 0; k < NBits; k++) begin
      for (int c = 0; c < Clks; c++) begin
        chk($sformatf("%s tx bit%0d c%0d", name, k, c), 32'(o_tx), 32'(exp[NBits-1-k]));
        chk($sformatf("%s done bit%0d c%0d", name, k, c), 32'(o_tx_done),
            32'(k == NBits - 1 && c == Clks - 1));
        chk($sformatf("%s busy bit%0d", name, k), 32'(o_busy), 32'd1);
        @(negedge rd_clk);
      end
    end
    chk({name, " byte_cnt"}, 32'(o_byte_cnt), 32'(cnt));
  endtask

  task automatic check_gap(input string name);
    int hi = 0;
    while (o_tx === 1'b1 && hi < 10) begin
      @(negedge rd_clk);
      hi++;
    end
    chk({name, " gap cycles"}, 32'(hi), 32'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'hA5, frame: 10'b0101001011, par: 1'b0};
    vecs[1] = '{data: 8'h00, frame: 10'b0000000001, par: 1'b0};
    vecs[2] = '{data: 8'hFF, frame: 10'b0111111111, par: 1'b0};
    vecs[3] = '{data: 8'h3C, frame: 10'b0001111001, par: 1'b0};
    vecs[4] = '{data: 8'h07, frame: 10'b0111000001, par: 1'b1};
    vecs[5] = '{data: 8'h03, frame: 10'b0110000001, par: 1'b0};
    vecs[6] = '{data: 8'h01, frame: 10'b0100000001, par: 1'b1};
    vecs[7] = '{data: 8'h80, frame: 10'b0000000011, par: 1'b1};

    // Reset values
    rd_rst_n = 1'b0;
    repeat (3) @(negedge rd_clk);
    chk("reset tx", 32'(o_tx), 32'd1);
    chk("reset rd_en", 32'(rd_en), 32'd0);
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset done", 32'(o_tx_done), 32'd0);
    chk("reset byte_cnt", 32'(o_byte_cnt), 32'd0);

    // FIFO non-empty while held in reset: no pop until after release
    push(vecs[0].data);
    @(negedge rd_clk);
    chk("in reset rd_en", 32'(rd_en), 32'd0);
    chk("in reset busy", 32'(o_busy), 32'd0);
    rd_rst_n = 1'b1;
    @(negedge rd_clk);
    chk("rd_en after first edge", 32'(rd_en), 32'd0);

    // Single bytes, FIFO drains between frames
    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      if (i != 0) push(vecs[i].data);
      wait_start(nm);
      check_frame(nm, expand(vecs[i]), 16'(i + 1));
      chk({nm, " idle busy"}, 32'(o_busy), 32'd0);
      chk({nm, " rd_en count"}, 32'(rd_en_cnt), 32'(i + 1));
    end

    // Back-to-back: FIFO never empty across three frames
    push(vecs[1].data);
    push(vecs[2].data);
    push(vecs[3].data);
    wait_start("b2b0");
    check_frame("b2b0", expand(vecs[1]), 16'd9);
    check_gap("b2b0");
    check_frame("b2b1", expand(vecs[2]), 16'd10);
    check_gap("b2b1");
    check_frame("b2b2", expand(vecs[3]), 16'd11);
    chk("b2b idle busy", 32'(o_busy), 32'd0);
    chk("b2b rd_en count", 32'(rd_en_cnt), 32'd11);

    // Reset during data bit 3 (a zero bit of 0xA5)
    push(vecs[0].data);
    wait_start("abort");
    repeat (17) @(negedge rd_clk);
    chk("abort tx before reset", 32'(o_tx), 32'd0);
    rd_rst_n = 1'b0;
    #1;
    chk("abort tx", 32'(o_tx), 32'd1);
    chk("abort busy", 32'(o_busy), 32'd0);
    chk("abort done", 32'(o_tx_done), 32'd0);
    chk("abort byte_cnt", 32'(o_byte_cnt), 32'd0);
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge rd_clk);
      chk("post abort tx", 32'(o_tx), 32'd1);
      chk("post abort done", 32'(o_tx_done), 32'd0);
    end
    chk("post abort byte_cnt", 32'(o_byte_cnt), 32'd0);
    chk("post abort rd_en count", 32'(rd_en_cnt), 32'd12);

    // Counter wrap: preset to 0xFFFF across an idle edge, then send one byte
    force dut.byte_cnt_q = 16'hFFFF;
    @(posedge rd_clk);
    @(negedge rd_clk);
    release dut.byte_cnt_q;
    @(negedge rd_clk);
    chk("preset byte_cnt", 32'(o_byte_cnt), 32'h0000FFFF);
    push(vecs[4].data);
    wait_start("wrap");
    check_frame("wrap", expand(vecs[4]), 16'h0000);

    // Long idle with empty FIFO
    for (int i = 0; i < 1000; i++) begin
      @(negedge rd_clk);
      chk("idle tx", 32'(o_tx), 32'd1);
      chk("idle busy", 32'(o_busy), 32'd0);
      chk("idle rd_en", 32'(rd_en), 32'd0);
    end
    chk("final rd_en count", 32'(rd_en_cnt), 32'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
